odometer_apb_master: RTL
========================

// Module: odometer_apb_master
// PURPOSE
//  APB4 requester (master) that drives the odometer APB slave ports (PADDR..PRDATA).
//  Converts a simple valid/ready command channel into one APB transfer: SETUP, then ACCESS.
//  Returns read data and error status on a valid/ready response channel.
//  Sits between the SAP host-side controller and the odometer slave wrappers.
// PARAMETERS
//  APB_ADDR_WIDTH    32   APB address width (from config_pkg.vh)
//  APB_DATA_WIDTH    32   APB data width (from config_pkg.vh)
//  APB_STROBE_WIDTH  4    byte strobes, APB_DATA_WIDTH/8 (from config_pkg.vh)
//  TIMEOUT_CYCLES    255  ACCESS wait limit, only used with APB_MST_TIMEOUT_EN
// PORTS
//  PCLK       in   1    single clock, rising edge
//  PRESETn    in   1    asynchronous active-low reset
//  cmd_valid  in   1    command present
//  cmd_ready  out  1    command accepted when valid&ready
//  cmd_write  in   1    1=write, 0=read
//  cmd_addr   in   AW   target address
//  cmd_wdata  in   DW   write data
//  cmd_strb   in   SW   write byte strobes
//  cmd_prot   in   3    protection attributes
//  rsp_valid  out  1    response present
//  rsp_ready  in   1    response consumed when valid&ready
//  rsp_rdata  out  DW   read data (0 for writes)
//  rsp_err    out  1    PSLVERR or timeout
//  PADDR      out  AW   / PWDATA out DW / PPROT out 3 / PSTRB out SW / PWRITE out 1
//  PSEL       out  1    slave select
//  PENABLE    out  1    access phase
//  PREADY     in   1    slave ready
//  PSLVERR    in   1    slave error, sampled only with PREADY in ACCESS
//  PRDATA     in   DW   read data, sampled only with PREADY in ACCESS on reads
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0 except cmd_ready=1. Async assert, sync release.
//  FSM IDLE->SETUP->ACCESS->RESP->IDLE.
//  IDLE: cmd_ready=1. On cmd_valid, register the command -> SETUP.
//  SETUP (1 cycle): PSEL=1, PENABLE=0, address/control/data from the register.
//  ACCESS: PSEL=1, PENABLE=1. Stay while PREADY=0. On PREADY=1:
//   capture rsp_rdata=PRDATA (reads) or 0 (writes); rsp_err=PSLVERR; then -> RESP.
//  RESP: PSEL=PENABLE=0, rsp_valid=1 and held with stable data until rsp_ready.
//   Then -> IDLE.
//  cmd_ready=0 in every state except IDLE; one transfer outstanding, no pipelining.
//  Min latency: accept at T0, SETUP T1, ACCESS T2 (PREADY=1), rsp_valid at T3.
//   Throughput is at most 1 transfer per 4 cycles.
//  PADDR/PWRITE/PWDATA/PSTRB/PPROT stable from SETUP through ACCESS.
//   They keep their last value when idle.
//  PSTRB is forced to 0 on reads. PWDATA is don't-care on reads but driven from the register.
//  rsp_ready is ignored outside RESP. cmd_valid is ignored outside IDLE.
//  Reset mid-transfer: FSM returns to IDLE immediately; PSEL/PENABLE drop to 0 asynchronously.
//   The pending response is discarded.
// CONFIGURATION
//  APB_MST_TIMEOUT_EN defined:
//   Counter clears on entry to ACCESS and increments each ACCESS cycle with PREADY=0.
//   When it reaches TIMEOUT_CYCLES with PREADY still 0, the transfer aborts -> RESP
//    with rsp_err=1, rsp_rdata=0.
//   If PREADY=1 in the same cycle, the normal completion wins.
//  Not defined: no counter; ACCESS waits indefinitely for PREADY; TIMEOUT_CYCLES unused.
// STRUCTURE
//  config_pkg.vh: APB_ADDR_WIDTH, APB_DATA_WIDTH, APB_STROBE_WIDTH, FSM state encodings
//   (ST_IDLE, ST_SETUP, ST_ACCESS, ST_RESP, 2 bits), TIMEOUT_CYCLES default.
//  Single module; the timeout counter is inline under `ifdef. No sub-module.
// TESTING
//  1. Write 0x10=0xDEADBEEF, strb 0xF, PREADY=1 -> PSEL at T1, PENABLE at T2;
//     rsp_valid T3, rsp_err=0, rsp_rdata=0.
//  2. Read 0x14, slave waits 3 cycles, PRDATA=0x0000_1234 -> ACCESS lasts 4 cycles;
//     rsp_rdata=0x1234; PSTRB=0 throughout.
//  3. Read with PSLVERR=1 on the PREADY cycle -> rsp_err=1; PSLVERR ignored in earlier wait cycles.
//  4. rsp_ready held 0 for 5 cycles -> rsp_valid/rsp_rdata stable; cmd_ready=0 until handshake.
//  5. PRESETn low during ACCESS -> PSEL=PENABLE=rsp_valid=0 same cycle; cmd_ready=1 after release.
//  6. APB_MST_TIMEOUT_EN, TIMEOUT_CYCLES=8, PREADY stuck 0 -> rsp_err=1, rsp_rdata=0,
//     PSEL drops after 8 ACCESS cycles.

Source files
------------

// File: rtl/odometer_apb_master_pkg.sv
// Shared constants and state encoding for the odometer APB requester.
package odometer_apb_master_pkg;

  localparam int DEF_APB_ADDR_WIDTH   = 32;
  localparam int DEF_APB_DATA_WIDTH   = 32;
  localparam int DEF_APB_STROBE_WIDTH = DEF_APB_DATA_WIDTH / 8;
  localparam int DEF_TIMEOUT_CYCLES   = 255;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } apb_state_e;

endpackage

// File: rtl/odometer_apb_master.sv
// APB4 requester for the odometer slave wrappers: one command in, one APB
// transfer (SETUP then ACCESS), one response out. No pipelining.
// Optional ACCESS wait limit enabled by defining APB_MST_TIMEOUT_EN.
//
// state     | meaning
// ----------+----------------------------------------------------------
// ST_IDLE   | cmd_ready=1, waiting for a command
// ST_SETUP  | PSEL=1, PENABLE=0, registered command on the bus
// ST_ACCESS | PSEL=1, PENABLE=1, waiting for PREADY (or timeout)
// ST_RESP   | rsp_valid=1, holding response until rsp_ready
module odometer_apb_master
   import odometer_apb_master_pkg::*;
#(
   parameter int APB_ADDR_WIDTH   = DEF_APB_ADDR_WIDTH,
   parameter int APB_DATA_WIDTH   = DEF_APB_DATA_WIDTH,
   parameter int APB_STROBE_WIDTH = DEF_APB_STROBE_WIDTH,
   parameter int TIMEOUT_CYCLES   = DEF_TIMEOUT_CYCLES
) (
   input  logic                        PCLK,
   input  logic                        PRESETn,
   input  logic                        cmd_valid,
   output logic                        cmd_ready,
   input  logic                        cmd_write,
   input  logic [APB_ADDR_WIDTH-1:0]   cmd_addr,
   input  logic [APB_DATA_WIDTH-1:0]   cmd_wdata,
   input  logic [APB_STROBE_WIDTH-1:0] cmd_strb,
   input  logic [2:0]                  cmd_prot,
   output logic                        rsp_valid,
   input  logic                        rsp_ready,
   output logic [APB_DATA_WIDTH-1:0]   rsp_rdata,
   output logic                        rsp_err,
   output logic [APB_ADDR_WIDTH-1:0]   PADDR,
   output logic [APB_DATA_WIDTH-1:0]   PWDATA,
   output logic [2:0]                  PPROT,
   output logic [APB_STROBE_WIDTH-1:0] PSTRB,
   output logic                        PWRITE,
   output logic                        PSEL,
   output logic                        PENABLE,
   input  logic                        PREADY,
   input  logic                        PSLVERR,
   input  logic [APB_DATA_WIDTH-1:0]   PRDATA
);

   apb_state_e                  state_q, state_d;
   logic [APB_ADDR_WIDTH-1:0]   addr_q;
   logic [APB_DATA_WIDTH-1:0]   wdata_q;
   logic [APB_DATA_WIDTH-1:0]   rdata_q;
   logic [APB_STROBE_WIDTH-1:0] strb_q;
   logic [2:0]                  prot_q;
   logic                        write_q;
   logic                        err_q;
   logic                        timeout_hit;

`ifdef APB_MST_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [CNT_W-1:0] to_cnt_q;

   // Count ACCESS wait cycles; cleared while in SETUP so each transfer starts at 0.
   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         to_cnt_q <= '0;
      end else if (state_q == ST_SETUP) begin
         to_cnt_q <= '0;
      end else if (state_q == ST_ACCESS && !PREADY) begin
         to_cnt_q <= to_cnt_q + 1'b1;
      end
   end

   // Abort on the last allowed wait cycle; a PREADY in that cycle still completes normally.
   assign timeout_hit = (state_q == ST_ACCESS) && !PREADY &&
                        (to_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`else
   assign timeout_hit = 1'b0;
`endif

   // State register; PSEL/PENABLE decode from it so reset drops them asynchronously.
   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) state_q <= ST_IDLE;
      else          state_q <= state_d;
   end

   // Next-state decode.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:   if (cmd_valid) state_d = ST_SETUP;
         ST_SETUP:  state_d = ST_ACCESS;
         ST_ACCESS: if (PREADY || timeout_hit) state_d = ST_RESP;
         ST_RESP:   if (rsp_ready) state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
   end

   // Command register; holds its value between transfers so the bus stays quiet.
   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         addr_q  <= '0;
         wdata_q <= '0;
         strb_q  <= '0;
         prot_q  <= '0;
         write_q <= 1'b0;
      end else if (state_q == ST_IDLE && cmd_valid) begin
         addr_q  <= cmd_addr;
         wdata_q <= cmd_wdata;
         strb_q  <= cmd_write ? cmd_strb : '0;
         prot_q  <= cmd_prot;
         write_q <= cmd_write;
      end
   end

   // Response capture at the end of ACCESS (completion or timeout).
   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else if (state_q == ST_ACCESS) begin
         if (PREADY) begin
            rdata_q <= write_q ? '0 : PRDATA;
            err_q   <= PSLVERR;
         end else if (timeout_hit) begin
            rdata_q <= '0;
            err_q   <= 1'b1;
         end
      end
   end

   assign cmd_ready = (state_q == ST_IDLE);
   assign PSEL      = (state_q == ST_SETUP) || (state_q == ST_ACCESS);
   assign PENABLE   = (state_q == ST_ACCESS);
   assign rsp_valid = (state_q == ST_RESP);
   assign rsp_rdata = rdata_q;
   assign rsp_err   = err_q;
   assign PADDR     = addr_q;
   assign PWDATA    = wdata_q;
   assign PSTRB     = strb_q;
   assign PPROT     = prot_q;
   assign PWRITE    = write_q;

endmodule
